// File: rtl/mor1kx_tlb_reload_arbiter_pkg.sv
// Shared types and constants for the IMMU/DMMU TLB-reload read-port arbiter.
// Grant bit positions are fixed so software-visible debug views of grant_o stay stable.
package mor1kx_tlb_reload_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_GAP    = 2'd2
    } arb_state_t;

    localparam int unsigned GRANT_IMMU = 0;
    localparam int unsigned GRANT_DMMU = 1;

    // Round-robin on a tie: whoever did not own the port last time goes first.
    function automatic logic [1:0] arbitrate(input logic immu_req,
                                             input logic dmmu_req,
                                             input logic last_was_dmmu);
        logic [1:0] g;
        g = 2'b00;
        if (immu_req && dmmu_req) begin
            if (last_was_dmmu)
                g[GRANT_IMMU] = 1'b1;
            else
                g[GRANT_DMMU] = 1'b1;
        end else if (immu_req) begin
            g[GRANT_IMMU] = 1'b1;
        end else if (dmmu_req) begin
            g[GRANT_DMMU] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Shares one bus read port between the IMMU and DMMU reload walkers, locking
// the grant for a whole page-table walk and enforcing a bus timeout.
module mor1kx_tlb_reload_arbiter
    import mor1kx_tlb_reload_arbiter_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_TIMEOUT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
    output logic                            immu_err_o,

    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
    output logic                            dmmu_err_o,

    output logic                            bus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_o,
    input  logic                            bus_ack_i,
    input  logic                            bus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,

    output logic [1:0]                      grant_o,
    output logic                            busy_o
);

    arb_state_t                      state_q, state_d;
    logic [1:0]                      grant_q, grant_d;
    logic                            bus_req_q, bus_req_d;
    logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_q, bus_adr_d;
    logic [OPTION_TIMEOUT_WIDTH-1:0] timer_q, timer_d;
    logic                            last_dmmu_q, last_dmmu_d;

    logic                            in_access;
    logic                            timeout;
    logic                            fault;
    logic                            owner_req;
    logic [OPTION_OPERAND_WIDTH-1:0] owner_addr;
    logic [1:0]                      new_grant;
    logic                            immu_live;
    logic                            dmmu_live;

    assign in_access  = (state_q == ARB_ACCESS);
    assign timeout    = (timer_q == {OPTION_TIMEOUT_WIDTH{1'b1}});
    assign fault      = bus_err_i | timeout;
    assign owner_req  = (grant_q[GRANT_IMMU] & immu_req_i) |
                        (grant_q[GRANT_DMMU] & dmmu_req_i);
    assign owner_addr = grant_q[GRANT_DMMU] ? dmmu_addr_i : immu_addr_i;
    assign new_grant  = arbitrate(immu_req_i, dmmu_req_i, last_dmmu_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_adr_q   <= '0;
            timer_q     <= '0;
            last_dmmu_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            bus_req_q   <= bus_req_d;
            bus_adr_q   <= bus_adr_d;
            timer_q     <= timer_d;
            last_dmmu_q <= last_dmmu_d;
        end
    end

    // ACCESS always runs to a bus answer or a timeout, even if the owner has
    // abandoned its walk, so the bus never sees a half-finished read.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        bus_req_d   = bus_req_q;
        bus_adr_d   = bus_adr_q;
        timer_d     = timer_q;
        last_dmmu_d = last_dmmu_q;

        case (state_q)
            ARB_IDLE: begin
                if (new_grant != 2'b00) begin
                    grant_d   = new_grant;
                    bus_adr_d = new_grant[GRANT_DMMU] ? dmmu_addr_i : immu_addr_i;
                    bus_req_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ARB_ACCESS;
                end
            end

            ARB_ACCESS: begin
                timer_d = timer_q + 1'b1;
                if (fault || bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = ARB_GAP;
                end
            end

            ARB_GAP: begin
                if (owner_req) begin
                    bus_adr_d = owner_addr;
                    bus_req_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ARB_ACCESS;
                end else begin
                    last_dmmu_d = grant_q[GRANT_DMMU];
                    grant_d     = 2'b00;
                    state_d     = ARB_IDLE;
                end
            end

            default: begin
                grant_d   = 2'b00;
                bus_req_d = 1'b0;
                state_d   = ARB_IDLE;
            end
        endcase
    end

    // Responses only reach an owner that is still walking; an error beats an ack.
    assign immu_live   = in_access & grant_q[GRANT_IMMU] & immu_req_i;
    assign dmmu_live   = in_access & grant_q[GRANT_DMMU] & dmmu_req_i;

    assign immu_err_o  = immu_live & fault;
    assign immu_ack_o  = immu_live & bus_ack_i & ~fault;
    assign dmmu_err_o  = dmmu_live & fault;
    assign dmmu_ack_o  = dmmu_live & bus_ack_i & ~fault;

    assign immu_data_o = grant_q[GRANT_IMMU] ? bus_dat_i : '0;
    assign dmmu_data_o = grant_q[GRANT_DMMU] ? bus_dat_i : '0;

    assign bus_req_o   = bus_req_q;
    assign bus_adr_o   = bus_adr_q;
    assign grant_o     = grant_q;
    assign busy_o      = |grant_q;

endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// Scoreboard bench for the TLB-reload arbiter: the driver plays both MMU walkers
// and the bus, queuing expected responses that a negedge monitor checks.
module tb_mor1kx_tlb_reload_arbiter;

    localparam int OW   = 32;
    localparam int TW   = 4;
    localparam int IMMU = 0;
    localparam int DMMU = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          immu_req_i = 1'b0;
    logic [OW-1:0] immu_addr_i = '0;
    logic          immu_ack_o;
    logic [OW-1:0] immu_data_o;
    logic          immu_err_o;
    logic          dmmu_req_i = 1'b0;
    logic [OW-1:0] dmmu_addr_i = '0;
    logic          dmmu_ack_o;
    logic [OW-1:0] dmmu_data_o;
    logic          dmmu_err_o;
    logic          bus_req_o;
    logic [OW-1:0] bus_adr_o;
    logic          bus_ack_i = 1'b0;
    logic          bus_err_i = 1'b0;
    logic [OW-1:0] bus_dat_i = '0;
    logic [1:0]    grant_o;
    logic          busy_o;

    mor1kx_tlb_reload_arbiter #(
        .OPTION_OPERAND_WIDTH (OW),
        .OPTION_TIMEOUT_WIDTH (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .immu_req_i  (immu_req_i),
        .immu_addr_i (immu_addr_i),
        .immu_ack_o  (immu_ack_o),
        .immu_data_o (immu_data_o),
        .immu_err_o  (immu_err_o),
        .dmmu_req_i  (dmmu_req_i),
        .dmmu_addr_i (dmmu_addr_i),
        .dmmu_ack_o  (dmmu_ack_o),
        .dmmu_data_o (dmmu_data_o),
        .dmmu_err_o  (dmmu_err_o),
        .bus_req_o   (bus_req_o),
        .bus_adr_o   (bus_adr_o),
        .bus_ack_i   (bus_ack_i),
        .bus_err_i   (bus_err_i),
        .bus_dat_i   (bus_dat_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // flags = {immu_ack, immu_err, dmmu_ack, dmmu_err}
    typedef struct {
        logic [3:0]    flags;
        logic [OW-1:0] data;
        int            cycle;
    } resp_t;

    resp_t expQ[$];
    int    lastWinner = DMMU;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int winnerOf(input bit i, input bit d);
        if (i && d) return (lastWinner == DMMU) ? IMMU : DMMU;
        return i ? IMMU : DMMU;
    endfunction

    function automatic logic [1:0] grantBits(input int owner);
        return (owner == IMMU) ? 2'b01 : 2'b10;
    endfunction

    // Monitor: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [3:0] f;
        resp_t      e;
        f = {immu_ack_o, immu_err_o, dmmu_ack_o, dmmu_err_o};
        if (f != 4'b0000) begin
            if (expQ.size() == 0) begin
                check("unexpected_response", {60'd0, f}, 64'd0);
            end else begin
                e = expQ.pop_front();
                check("resp_flags", {60'd0, f}, {60'd0, e.flags});
                check("resp_cycle", cyc, e.cycle);
                if (e.flags[3]) check("immu_data", immu_data_o, e.data);
                if (e.flags[1]) check("dmmu_data", dmmu_data_o, e.data);
            end
        end
    end

    task automatic setReq(input int owner, input bit r, input logic [OW-1:0] a);
        if (owner == IMMU) begin
            immu_req_i  = r;
            immu_addr_i = a;
        end else begin
            dmmu_req_i  = r;
            dmmu_addr_i = a;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 ack, 1 err, 2 err+ack, 3 no answer (timeout after lat cycles)
    task automatic applyStimulus(input int owner, input logic [OW-1:0] expAddr, input int expWait,
                                 input int lat, input int mode, input logic [OW-1:0] data,
                                 input bit last, input logic [OW-1:0] nextAddr);
        int    n;
        resp_t e;
        n = 0;
        do begin
            nextCycle();
            n++;
        end while (!bus_req_o && n < 200);
        if (!bus_req_o) begin
            check("bus_req_wait_expired", 64'd0, 64'd1);
            return;
        end
        check("req_latency", n, expWait);
        check("grant", grant_o, grantBits(owner));
        check("busy", busy_o, 1);
        check("bus_adr", bus_adr_o, expAddr);
        repeat (lat) nextCycle();
        e.flags = (mode == 0) ? ((owner == IMMU) ? 4'b1000 : 4'b0010)
                              : ((owner == IMMU) ? 4'b0100 : 4'b0001);
        e.data  = data;
        e.cycle = cyc;
        if (mode == 1 || mode == 2) bus_err_i = 1'b1;
        if (mode == 0 || mode == 2) bus_ack_i = 1'b1;
        bus_dat_i = data;
        expQ.push_back(e);
        nextCycle();
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        check("gap_bus_req", bus_req_o, 0);
        check("gap_grant", grant_o, grantBits(owner));
        setReq(owner, !last, nextAddr);
    endtask

    task automatic walk(input int owner, input logic [OW-1:0] firstAddr, input int firstWait,
                        input int nReads, input bit randErr);
        logic [OW-1:0] a;
        logic [OW-1:0] nxt;
        int            mode;
        a = firstAddr;
        for (int i = 0; i < nReads; i++) begin
            nxt  = $urandom;
            mode = 0;
            if (randErr && $urandom_range(0, 5) == 0) mode = $urandom_range(1, 2);
            applyStimulus(owner, a, (i == 0) ? firstWait : 1, $urandom_range(0, 4), mode,
                          $urandom, i == nReads - 1, nxt);
            a = nxt;
        end
        lastWinner = owner;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_bus_req"}, bus_req_o, 0);
        check({tag, "_grant"}, grant_o, 0);
        check({tag, "_busy"}, busy_o, 0);
    endtask

    task automatic tieRound(input int nW, input int nL, input bit randErr);
        int            w;
        int            l;
        logic [OW-1:0] aw;
        logic [OW-1:0] al;
        w  = winnerOf(1'b1, 1'b1);
        l  = (w == IMMU) ? DMMU : IMMU;
        aw = $urandom;
        al = $urandom;
        setReq(w, 1'b1, aw);
        setReq(l, 1'b1, al);
        walk(w, aw, 1, nW, randErr);
        walk(l, al, 2, nL, randErr);
        nextCycle();
    endtask

    initial begin
        logic [OW-1:0] a;
        int            sel;
        int            owner;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        check("reset_bus_adr", bus_adr_o, 0);
        check("reset_responses", {immu_ack_o, immu_err_o, dmmu_ack_o, dmmu_err_o}, 0);
        rst = 1'b0;

        $display("[TB] simultaneous first requests");
        tieRound(2, 2, 1'b0);

        $display("[TB] single IMMU walk, zero-wait bus");
        setReq(IMMU, 1'b1, 32'h0000_1000);
        applyStimulus(IMMU, 32'h0000_1000, 1, 0, 0, 32'h0040_2000, 1'b0, 32'h0040_2ABC);
        applyStimulus(IMMU, 32'h0040_2ABC, 1, 0, 0, $urandom, 1'b1, 32'h0);
        lastWinner = IMMU;
        nextCycle();
        checkOutput("walk_end");

        $display("[TB] repeated simultaneous requests");
        tieRound(1, 2, 1'b0);

        $display("[TB] lock test");
        a = $urandom;
        setReq(IMMU, 1'b1, a);
        applyStimulus(IMMU, a, 1, 1, 0, $urandom, 1'b0, 32'h0000_2000);
        setReq(DMMU, 1'b1, 32'h0000_3000);
        applyStimulus(IMMU, 32'h0000_2000, 1, 2, 0, $urandom, 1'b0, 32'h0000_2004);
        applyStimulus(IMMU, 32'h0000_2004, 1, 0, 0, $urandom, 1'b1, 32'h0);
        walk(DMMU, 32'h0000_3000, 2, 1, 1'b0);
        nextCycle();

        $display("[TB] bus error with ack");
        setReq(IMMU, 1'b1, 32'h0000_4000);
        applyStimulus(IMMU, 32'h0000_4000, 1, 1, 2, $urandom, 1'b1, 32'h0);
        lastWinner = IMMU;
        nextCycle();

        $display("[TB] timeout");
        setReq(DMMU, 1'b1, 32'h0000_5000);
        applyStimulus(DMMU, 32'h0000_5000, 1, (1 << TW) - 1, 3, 32'h0, 1'b1, 32'h0);
        lastWinner = DMMU;
        nextCycle();

        $display("[TB] owner drops request mid-access");
        setReq(IMMU, 1'b1, 32'h0000_6000);
        nextCycle();
        check("drop_bus_req", bus_req_o, 1);
        setReq(IMMU, 1'b0, 32'h0);
        nextCycle();
        bus_ack_i = 1'b1;
        bus_dat_i = $urandom;
        nextCycle();
        bus_ack_i = 1'b0;
        check("drop_gap_bus_req", bus_req_o, 0);
        check("drop_gap_grant", grant_o, 2'b01);
        nextCycle();
        checkOutput("drop_idle");
        lastWinner = IMMU;

        $display("[TB] async reset mid-access");
        setReq(IMMU, 1'b1, 32'h0000_7000);
        nextCycle();
        check("rst_pre_bus_req", bus_req_o, 1);
        #2 rst = 1'b1;
        #1 checkOutput("async_rst");
        setReq(IMMU, 1'b0, 32'h0);
        nextCycle();
        rst       = 1'b0;
        bus_ack_i = 1'b1;
        nextCycle();
        bus_ack_i = 1'b0;
        checkOutput("post_rst");
        lastWinner = DMMU;

        $display("[TB] randomized walks");
        for (int it = 0; it < 24; it++) begin
            sel = $urandom_range(1, 3);
            if (sel == 3) begin
                tieRound($urandom_range(1, 3), $urandom_range(1, 3), 1'b1);
            end else begin
                owner = (sel == 1) ? IMMU : DMMU;
                a     = $urandom;
                setReq(owner, 1'b1, a);
                walk(owner, a, 1, $urandom_range(1, 3), 1'b1);
                nextCycle();
            end
            repeat ($urandom_range(0, 2)) nextCycle();
        end

        repeat (5) nextCycle();
        check("scoreboard_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
